// File: rtl/field_scan_gen.sv
// field_scan_gen: raster sweep of a FIELD_W x FIELD_H cell field, LANES cells per beat.
// Latency: the first beat is valid right after the edge that samples i_go; back-to-back beats
//   while i_ready is high.
// Backpressure: i_ready=0 holds every output unchanged; i_abort stops the sweep at the next edge.
// Optional: `define FIELD_SCAN_CONTINUOUS_EN adds i_continuous for gapless back-to-back frames.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_go, i_abort          start a sweep (sampled in IDLE) / stop the sweep
//   i_ready                consumer accepts the current beat
//   i_continuous           (optional) wrap to (0,0) after the last beat instead of going idle
//   o_valid, o_busy        beat valid / scanning (identical)
//   o_cur_x, o_cur_y       lane-0 x and row of the current beat
//   o_lane_mask            bit k set when cell o_cur_x+k lies inside the field
//   o_first, o_last        beat is (0,0) / beat is the final group of the last row
//   o_done                 one-cycle pulse after the last beat is accepted
module field_scan_gen #(
  parameter int FIELD_W = 5,
  parameter int FIELD_H = 3,
  parameter int LANES   = 1,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_go,
  input  logic                  i_abort,
  input  logic                  i_ready,
`ifdef FIELD_SCAN_CONTINUOUS_EN
  input  logic                  i_continuous,
`endif
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [X_ADR_SIZE-1:0] o_cur_x,
  output logic [Y_ADR_SIZE-1:0] o_cur_y,
  output logic [LANES-1:0]      o_lane_mask,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_done
);

  // One extra bit so x + LANES (at most 2*FIELD_W-1) cannot wrap.
  localparam int XW = X_ADR_SIZE + 1;
  localparam logic [XW-1:0]         LANES_EXT   = XW'(LANES);
  localparam logic [XW-1:0]         FIELD_W_EXT = XW'(FIELD_W);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST      = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [X_ADR_SIZE-1:0] x_q, x_d;
  logic [Y_ADR_SIZE-1:0] y_q, y_d;
  logic                  done_q, done_d;

  logic [XW-1:0] x_ext;
  logic [XW-1:0] x_sum;
  logic          row_end;
  logic          last_row;
  logic          accept;
  logic          wrap;

  assign x_ext    = {1'b0, x_q};
  assign x_sum    = x_ext + LANES_EXT;
  assign row_end  = (x_sum >= FIELD_W_EXT);
  assign last_row = (y_q == Y_LAST);
  assign accept   = (state_q == SCAN) && i_ready;

`ifdef FIELD_SCAN_CONTINUOUS_EN
  assign wrap = i_continuous;
`else
  assign wrap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Next state; abort outranks both i_go and an accepting handshake.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_go && !i_abort) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        if (i_abort) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (accept) begin
          if (row_end && last_row) begin
            state_d = wrap ? SCAN : IDLE;
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b1;
          end else if (row_end) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_sum[X_ADR_SIZE-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_valid     = (state_q == SCAN);
    o_busy      = (state_q == SCAN);
    o_cur_x     = x_q;
    o_cur_y     = y_q;
    o_first     = (state_q == SCAN) && (x_q == '0) && (y_q == '0);
    o_last      = (state_q == SCAN) && row_end && last_row;
    o_done      = done_q;
    o_lane_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      o_lane_mask[k] = (state_q == SCAN) && ((x_ext + XW'(k)) < FIELD_W_EXT);
    end
  end

endmodule

// File: tb/tb_field_scan_gen.sv
module tb_field_scan_gen;

  localparam int W = 5;
  localparam int H = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  // DUT0: LANES=1
  logic go0, abort0, ready0, cont0;
  logic v0, b0, f0, l0, d0;
  logic [2:0] x0;
  logic [1:0] y0;
  logic [0:0] m0;
  // DUT1: LANES=2
  logic go1, abort1, ready1;
  logic v1, b1, f1, l1, d1;
  logic [2:0] x1;
  logic [1:0] y1;
  logic [1:0] m1;

  field_scan_gen #(.FIELD_W(W), .FIELD_H(H), .LANES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_go(go0), .i_abort(abort0), .i_ready(ready0),
`ifdef FIELD_SCAN_CONTINUOUS_EN
    .i_continuous(cont0),
`endif
    .o_valid(v0), .o_busy(b0), .o_cur_x(x0), .o_cur_y(y0), .o_lane_mask(m0),
    .o_first(f0), .o_last(l0), .o_done(d0)
  );

  field_scan_gen #(.FIELD_W(W), .FIELD_H(H), .LANES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_go(go1), .i_abort(abort1), .i_ready(ready1),
`ifdef FIELD_SCAN_CONTINUOUS_EN
    .i_continuous(1'b0),
`endif
    .o_valid(v1), .o_busy(b1), .o_cur_x(x1), .o_cur_y(y1), .o_lane_mask(m1),
    .o_first(f1), .o_last(l1), .o_done(d1)
  );

  typedef struct {
    int x;
    int y;
    int mask;
    bit first;
    bit last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    total = 0;
  int    bad   = 0;
  int    acc[2];
  bit    exp_done[2];
  bit    prev_mid[2];
  bit    cont_mode = 1'b0;
  bit    mon_en    = 1'b0;
  bit    rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference sweep: rows top to bottom, groups of `lanes` cells left to right.
  task automatic push_frame(input int id, input int lanes);
    beat_t b;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x += lanes) begin
        b.x = x;
        b.y = y;
        b.mask = 0;
        for (int k = 0; k < lanes; k++) if (x + k < W) b.mask |= (1 << k);
        b.first = (x == 0) && (y == 0);
        b.last  = (y == H - 1) && (x + lanes >= W);
        if (id == 0) q0.push_back(b); else q1.push_back(b);
      end
    end
  endtask

  task automatic mon(input int id, input int v, input int bsy, input int x, input int y,
                     input int m, input int f, input int l, input int d,
                     input int rdy, input int ab);
    beat_t e;
    int    qs;
    chk($sformatf("busy_eq_valid%0d", id), bsy, v);
    chk($sformatf("done%0d", id), d, int'(exp_done[id]));
    exp_done[id] = 1'b0;
    qs = (id == 0) ? q0.size() : q1.size();
    if (v != 0) begin
      if (qs == 0) begin
        chk($sformatf("unexpected_beat%0d", id), v, 0);
      end else begin
        e = (id == 0) ? q0[0] : q1[0];
        chk($sformatf("x%0d", id), x, e.x);
        chk($sformatf("y%0d", id), y, e.y);
        chk($sformatf("mask%0d", id), m, e.mask);
        chk($sformatf("first%0d", id), f, int'(e.first));
        chk($sformatf("last%0d", id), l, int'(e.last));
        if (ab != 0) begin
          if (id == 0) q0.delete(); else q1.delete();
          prev_mid[id] = 1'b0;
        end else if (rdy != 0) begin
          if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          acc[id]++;
          exp_done[id] = e.last;
          prev_mid[id] = !e.last || cont_mode;
        end else begin
          prev_mid[id] = 1'b0;
        end
      end
    end else begin
      chk($sformatf("idle_outputs%0d", id), x | y | m | f | l, 0);
      chk($sformatf("bubble%0d", id), int'(prev_mid[id]), 0);
      prev_mid[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, int'(v0), int'(b0), int'(x0), int'(y0), int'(m0), int'(f0), int'(l0), int'(d0),
          int'(ready0), int'(abort0));
      mon(1, int'(v1), int'(b1), int'(x1), int'(y1), int'(m1), int'(f1), int'(l1), int'(d1),
          int'(ready1), int'(abort1));
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 ready0 = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, input int budget);
    int n = 0;
    while (((id == 0) ? d0 : d1) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("done_seen%0d", id), int'((id == 0) ? d0 : d1), 1);
  endtask

  task automatic start0();
    go0 = 1'b1;
    push_frame(0, 1);
    tick();
    go0 = 1'b0;
  endtask

  initial begin
    int n;
    go0 = 0; abort0 = 0; ready0 = 0; cont0 = 0;
    go1 = 0; abort1 = 0; ready1 = 1;
    acc[0] = 0; acc[1] = 0;
    exp_done[0] = 0; exp_done[1] = 0;
    prev_mid[0] = 0; prev_mid[1] = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_state0", int'({v0, b0, x0, y0, m0, f0, l0, d0}), 0);
    chk("reset_state1", int'({v1, b1, x1, y1, m1, f1, l1, d1}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Three LANES=1 frames with i_ready held high; the last go lands in the done cycle.
    ready0 = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      acc[0] = 0;
      start0();
      chk("first_beat_valid", int'(v0), 1);
      wait_done(0, 100);
      chk("beats_per_frame", acc[0], 15);
      if (fr == 0) repeat ($urandom_range(1, 10)) tick();
    end
    tick();

    // LANES=2 frame: 9 beats with partial final groups.
    acc[1] = 0;
    go1 = 1'b1;
    push_frame(1, 2);
    tick();
    go1 = 1'b0;
    wait_done(1, 100);
    chk("beats_per_frame_l2", acc[1], 9);
    repeat (3) tick();

    // Random backpressure.
    acc[0] = 0;
    rand_ready = 1'b1;
    start0();
    wait_done(0, 1000);
    chk("beats_stalled", acc[0], 15);
    rand_ready = 1'b0;
    tick();
    ready0 = 1'b1;
    repeat (2) tick();

    // Abort at (2,1) together with an accepting handshake.
    start0();
    n = 0;
    while (!(v0 && x0 == 3'd2 && y0 == 2'd1) && n < 50) begin
      tick();
      n++;
    end
    chk("reach_2_1", int'(v0 && x0 == 3'd2 && y0 == 2'd1), 1);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    chk("abort_idle", int'({v0, x0, y0}), 0);
    tick();
    chk("abort_no_done", int'(d0), 0);

    // i_go during SCAN must not restart the sweep.
    acc[0] = 0;
    start0();
    repeat (4) tick();
    go0 = 1'b1;
    tick();
    go0 = 1'b0;
    wait_done(0, 100);
    chk("go_in_scan_beats", acc[0], 15);
    tick();

    // i_abort + i_go in IDLE stays idle.
    abort0 = 1'b1;
    go0 = 1'b1;
    tick();
    abort0 = 1'b0;
    go0 = 1'b0;
    chk("abort_go_idle", int'(v0), 0);
    repeat (3) tick();

    // Asynchronous reset in the middle of a sweep.
    start0();
    n = 0;
    while (!(v0 && x0 == 3'd3 && y0 == 2'd0) && n < 50) begin
      tick();
      n++;
    end
    chk("reach_3_0", int'(v0 && x0 == 3'd3 && y0 == 2'd0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", int'({v0, b0, x0, y0, m0, f0, l0, d0}), 0);
    q0.delete();
    exp_done[0] = 1'b0;
    prev_mid[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("no_done_after_reset", int'(d0), 0);
    start0();
    chk("restart_origin", int'({v0, x0, y0, f0}), int'(10'b1_000_00_1));
    wait_done(0, 100);
    tick();

`ifdef FIELD_SCAN_CONTINUOUS_EN
    // Gapless frames; o_done after beats 15 and 30; abort stops the sweep.
    acc[0] = 0;
    cont_mode = 1'b1;
    cont0 = 1'b1;
    go0 = 1'b1;
    push_frame(0, 1);
    push_frame(0, 1);
    push_frame(0, 1);
    tick();
    go0 = 1'b0;
    wait_done(0, 100);
    chk("cont_done_1", acc[0], 15);
    chk("cont_still_valid", int'(v0), 1);
    tick();
    wait_done(0, 100);
    chk("cont_done_2", acc[0], 30);
    repeat (5) tick();
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    cont0 = 1'b0;
    cont_mode = 1'b0;
    chk("cont_abort", int'(v0), 0);
    repeat (3) tick();
`endif

    mon_en = 1'b0;
    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
